// File: rtl/count_stream_decoder.sv
// Observer for an up/down counter's output bus: classifies each sampled value against
// the previous one (step up/down, hold, jump), tracks direction lock and counts events.
module count_stream_decoder #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic [WIDTH-1:0]     count,
  output logic                 step_up,
  output logic                 step_down,
  output logic                 hold,
  output logic                 jump,
  output logic [WIDTH-1:0]     jump_value,
  output logic                 wrap,
  output logic                 dir,
  output logic                 locked,
  output logic [CNT_WIDTH-1:0] dir_chg_cnt,
  output logic [CNT_WIDTH-1:0] jump_cnt
);

  typedef enum logic [1:0] {EMPTY, ACQ, UP, DOWN} state_t;

  localparam logic [WIDTH-1:0]     ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0]     ALL_ONES = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] delta;
  logic             is_hold;
  logic             is_up;
  logic             is_down;
  logic             is_jump;

  // With WIDTH=1 a delta of 1 is also all-ones; step_up takes priority.
  always_comb begin
    delta   = count - prev;
    is_hold = (delta == '0);
    is_up   = (delta == ONE);
    is_down = !is_up && (delta == ALL_ONES);
    is_jump = !is_hold && !is_up && !is_down;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; mixing in blocking assignments would create ordering races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= EMPTY;
      prev        <= '0;
      step_up     <= 1'b0;
      step_down   <= 1'b0;
      hold        <= 1'b0;
      jump        <= 1'b0;
      wrap        <= 1'b0;
      jump_value  <= '0;
      dir         <= 1'b0;
      locked      <= 1'b0;
      dir_chg_cnt <= '0;
      jump_cnt    <= '0;
    end else begin
      // Pulses default low so they last exactly one cycle.
      step_up   <= 1'b0;
      step_down <= 1'b0;
      hold      <= 1'b0;
      jump      <= 1'b0;
      wrap      <= 1'b0;
      if (sample_en) begin
        prev <= count;
        if (state == EMPTY) begin
          state <= ACQ;
        end else begin
          step_up   <= is_up;
          step_down <= is_down;
          hold      <= is_hold;
          jump      <= is_jump;
          wrap      <= (is_up && prev == ALL_ONES) || (is_down && prev == '0);
          if (is_jump) begin
            jump_value <= count;
            if (jump_cnt != CNT_MAX) jump_cnt <= jump_cnt + CNT_ONE;
            state  <= ACQ;
            locked <= 1'b0;
          end else if (is_up) begin
            if (state == DOWN && dir_chg_cnt != CNT_MAX) dir_chg_cnt <= dir_chg_cnt + CNT_ONE;
            state  <= UP;
            locked <= 1'b1;
            dir    <= 1'b1;
          end else if (is_down) begin
            if (state == UP && dir_chg_cnt != CNT_MAX) dir_chg_cnt <= dir_chg_cnt + CNT_ONE;
            state  <= DOWN;
            locked <= 1'b1;
            dir    <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_count_stream_decoder.sv
// Bench for count_stream_decoder: directed scenarios plus random streams, checked every
// cycle against a behavioural model built from plain modular arithmetic.
module tb_count_stream_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_en = 1'b0;
  logic [7:0] count = 8'h00;
  logic       step_up, step_down, hold, jump, wrap, dir, locked;
  logic [7:0] jump_value, dir_chg_cnt, jump_cnt;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  count_stream_decoder #(.WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .count(count),
    .step_up(step_up), .step_down(step_down), .hold(hold), .jump(jump),
    .jump_value(jump_value), .wrap(wrap), .dir(dir), .locked(locked),
    .dir_chg_cnt(dir_chg_cnt), .jump_cnt(jump_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Behavioural model: direction is "locked + dir"; no notion of encoded states.
  bit       m_have = 1'b0;
  bit [7:0] m_prev = 8'h00;
  bit       m_locked = 1'b0;
  bit       m_dir = 1'b0;
  int       m_dchg = 0;
  int       m_jcnt = 0;
  bit [7:0] m_jval = 8'h00;
  bit       e_up = 1'b0, e_dn = 1'b0, e_hold = 1'b0, e_jump = 1'b0, e_wrap = 1'b0;

  always @(posedge clk or negedge reset) begin
    int d;
    if (!reset) begin
      m_have = 0; m_prev = 0; m_locked = 0; m_dir = 0; m_dchg = 0; m_jcnt = 0; m_jval = 0;
      e_up = 0; e_dn = 0; e_hold = 0; e_jump = 0; e_wrap = 0;
    end else begin
      e_up = 0; e_dn = 0; e_hold = 0; e_jump = 0; e_wrap = 0;
      if (sample_en) begin
        if (m_have) begin
          d = (int'(count) - int'(m_prev) + 256) % 256;
          if (d == 0) begin
            e_hold = 1;
          end else if (d == 1) begin
            e_up = 1;
            e_wrap = (m_prev == 8'd255);
            if (m_locked && !m_dir && m_dchg < 255) m_dchg++;
            m_locked = 1; m_dir = 1;
          end else if (d == 255) begin
            e_dn = 1;
            e_wrap = (m_prev == 8'd0);
            if (m_locked && m_dir && m_dchg < 255) m_dchg++;
            m_locked = 1; m_dir = 0;
          end else begin
            e_jump = 1;
            m_jval = count;
            if (m_jcnt < 255) m_jcnt++;
            m_locked = 0;
          end
        end
        m_have = 1;
        m_prev = count;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("step_up", 32'(step_up), 32'(e_up));
      check("step_down", 32'(step_down), 32'(e_dn));
      check("hold", 32'(hold), 32'(e_hold));
      check("jump", 32'(jump), 32'(e_jump));
      check("wrap", 32'(wrap), 32'(e_wrap));
      check("jump_value", 32'(jump_value), 32'(m_jval));
      check("dir", 32'(dir), 32'(m_dir));
      check("locked", 32'(locked), 32'(m_locked));
      check("dir_chg_cnt", 32'(dir_chg_cnt), 32'(m_dchg));
      check("jump_cnt", 32'(jump_cnt), 32'(m_jcnt));
    end
  end

  task automatic step(input logic en, input logic [7:0] v);
    sample_en = en;
    count     = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pulses"}, 32'({step_up, step_down, hold, jump, wrap}), 32'd0);
    check({tag, "_dir_locked"}, 32'({dir, locked}), 32'd0);
    check({tag, "_jump_value"}, 32'(jump_value), 32'd0);
    check({tag, "_counters"}, 32'({dir_chg_cnt, jump_cnt}), 32'd0);
  endtask

  logic [7:0] last_cnt;
  logic [7:0] v;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check_all_zero("reset");
    reset = 1'b1;

    // First sample silent, then steady up-count.
    step(1, 8'h00);
    check("first_silent", 32'({step_up, hold, jump, locked}), 32'd0);
    step(1, 8'h01);
    check("t1_up_lock", 32'({step_up, locked, dir}), 32'b111);
    step(1, 8'h02);
    step(1, 8'h03);
    check("t1_step_up3", 32'(step_up), 32'd1);

    step(1, 8'h14);
    check("t2_jump", 32'({jump, locked}), 32'b10);
    check("t2_jump_value", 32'(jump_value), 32'h14);
    check("t2_jump_cnt", 32'(jump_cnt), 32'd1);

    step(1, 8'h14);
    check("t3_hold", 32'(hold), 32'd1);
    step(1, 8'h13);
    step(1, 8'h12);
    check("t3_down_lock", 32'({step_down, locked, dir}), 32'b110);
    check("t3_dir_chg", 32'(dir_chg_cnt), 32'd0);

    step(1, 8'hFE);
    step(1, 8'hFF);
    check("t4_acq_up_nochg", 32'({step_up, locked, dir_chg_cnt}), {22'd0, 1'b1, 1'b1, 8'd0});
    step(1, 8'h00);
    check("t4_wrap_up", 32'({step_up, wrap}), 32'b11);
    step(1, 8'h00);
    check("t4_hold_nowrap", 32'({hold, wrap}), 32'b10);
    step(1, 8'hFF);
    check("t4_wrap_down", 32'({step_down, wrap, dir}), 32'b110);
    check("t4_dir_chg", 32'(dir_chg_cnt), 32'd1);

    // Idle cycles with a toggling bus must not disturb anything.
    for (int i = 0; i < 10; i++) step(0, 8'($urandom));
    step(1, 8'hFE);
    check("t5_prev_kept", 32'({step_down, wrap, jump}), 32'b100);

    // Random streams biased toward steps and wrap boundaries.
    last_cnt = 8'hFE;
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: v = last_cnt + 8'd1;
        3, 4, 5: v = last_cnt - 8'd1;
        6:       v = last_cnt;
        7:       v = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        default: v = 8'($urandom);
      endcase
      if ($urandom_range(0, 4) != 0) begin
        step(1, v);
        last_cnt = v;
      end else begin
        step(0, v);
      end
    end

    // Clear, then saturate the jump counter; reset in the middle of the burst.
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid_stream");
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step(1, (i % 2 == 0) ? 8'h00 : 8'h80);
      if (i == 280) begin
        check("t6_jump_sat", 32'(jump_cnt), 32'hFF);
        sample_en = 1'b1;
        count     = 8'h00;
        reset     = 1'b0;
        #1;
        check_all_zero("t6_reset_burst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1, 8'h80);
        check("t6_first_silent", 32'({jump, step_up, hold, locked, jump_cnt}), 32'd0);
      end
    end

    step(1, 8'h81);
    check("t6_step_after_reset", 32'(step_up), 32'd1);
    step(0, 8'h00);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
